multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/mult_pkg.sv | 14 +
 rtl/multiplier.sv | 127 ++++++++++++
 tb/tb_multiplier.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t    : controller states (IDLE accepts work, RUN iterates, FIX writes result)
//   MULT_WIDTH : default operand width
package mult_pkg;

  localparam int MULT_WIDTH = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage : mult_pkg

// File: rtl/multiplier.sv
// Sequential signed/unsigned multiplier, one shift-add step per clock.
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   sign         : 1 = two's-complement operands/product, sampled with start
//   start        : request, sampled only while ready=1
//   multiplicand : first operand, sampled with start
//   factor       : second operand, sampled with start
//   product      : registered result of the last completed multiply
//   ready        : idle, product valid, start accepted
//   ovf          : (MULTIPLIER_OVF_EN only) result does not fit WIDTH bits
// Optional feature macro: MULTIPLIER_OVF_EN adds the ovf output.
// Latency: accept edge -> WIDTH RUN cycles -> 1 FIX cycle -> IDLE.
module multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sign,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   factor,
  output logic [2*WIDTH-1:0] product,
  output logic               ready
`ifdef MULTIPLIER_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_t          state, state_nx;
  logic [PW-1:0]   acc;       // running magnitude of the product
  logic [PW-1:0]   mc_sh;     // multiplicand magnitude, shifted left per step
  logic [WIDTH:0]  fac_q;     // factor magnitude, bit cnt selects the add
  logic [CW-1:0]   cnt;
  logic            neg_q;     // result must be negated in FIX
  logic            accept;
  logic            last;

  // Magnitude in WIDTH+1 bits so the most negative value maps exactly.
  function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] x, input logic s);
    logic [WIDTH:0] ext;
    ext = {s & x[WIDTH-1], x};
    mag = ext[WIDTH] ? (~ext + 1'b1) : ext;
  endfunction

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(WIDTH - 1));

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = RUN;
      end
      RUN:     if (last) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      mc_sh   <= '0;
      fac_q   <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      product <= '0;
    end else begin
      if (accept) begin
        mc_sh <= PW'(mag(multiplicand, sign));
        fac_q <= mag(factor, sign);
        neg_q <= sign & (multiplicand[WIDTH-1] ^ factor[WIDTH-1]);
        acc   <= '0;
        cnt   <= '0;
      end
      if (state == RUN) begin
        if (fac_q[cnt]) acc <= acc + mc_sh;
        mc_sh <= mc_sh << 1;
        cnt   <= cnt + 1'b1;
      end
      if (state == FIX)
        product <= neg_q ? (~acc + 1'b1) : acc;
    end
  end

`ifdef MULTIPLIER_OVF_EN
  // Overflow is judged on the magnitude: a negative result may reach
  // 2^(WIDTH-1), a positive signed one only 2^(WIDTH-1)-1.
  logic          sign_q;
  logic          ovf_nx;
  logic [PW-1:0] lim;

  assign lim = PW'(1) << (WIDTH - 1);

  always_comb begin
    ovf_nx = 1'b0;
    if (sign_q) ovf_nx = neg_q ? (acc > lim) : (acc >= lim);
    else        ovf_nx = |acc[PW-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_q <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (accept)        sign_q <= sign;
      if (state == FIX)  ovf    <= ovf_nx;
    end
  end
`endif

endmodule : multiplier

// File: tb/tb_multiplier.sv
// Directed self-checking bench for multiplier (WIDTH = 13).
module tb_multiplier;

  localparam int W = 13;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           sign;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   factor;
  logic [2*W-1:0] product;
  logic           ready;
`ifdef MULTIPLIER_OVF_EN
  logic           ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sign         (sign),
    .start        (start),
    .multiplicand (multiplicand),
    .factor       (factor),
    .product      (product),
    .ready        (ready)
`ifdef MULTIPLIER_OVF_EN
    ,
    .ovf          (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Issue one operation and count edges until ready returns (-1 on timeout).
  task automatic do_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc);
    @(negedge clk);
    sign = s; multiplicand = a; factor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!ready) cyc = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sign = 1'b0; start = 1'b0; multiplicand = '0; factor = '0;
    #3;
    n_chk++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_chk++;
    if (product !== '0) begin n_fail++; $display("FAIL reset_product: got %h expected 0", product); end
`ifdef MULTIPLIER_OVF_EN
    n_chk++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int cyc;
    do_mul(1'b0, 13'd1404, 13'd5, cyc);
    n_chk++;
    if (cyc !== 14) begin n_fail++; $display("FAIL uns_latency: got %0d expected 14", cyc); end
    n_chk++;
    if (product !== 26'd7020) begin n_fail++; $display("FAIL uns_1404x5: got %h expected %h", product, 26'd7020); end
  endtask

  task automatic test_signed();
    int cyc;
    do_mul(1'b1, 13'h1FFD, 13'd7, cyc);
    n_chk++;
    if (product !== 26'h3FFFFEB) begin n_fail++; $display("FAIL sgn_m3x7: got %h expected 3ffffeb", product); end
    do_mul(1'b1, 13'h1000, 13'h1000, cyc);
    n_chk++;
    if (cyc !== 14) begin n_fail++; $display("FAIL sgn_latency: got %0d expected 14", cyc); end
    n_chk++;
    if (product !== 26'h1000000) begin n_fail++; $display("FAIL sgn_min_sq: got %h expected 1000000", product); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    sign = 1'b0; multiplicand = 13'h1FFF; factor = 13'h1FFF; start = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    multiplicand = 13'd2; factor = 13'd3;   // changed mid-run, must be ignored
    cyc = 1;
    while (!ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    n_chk++;
    if (product !== 26'h3FFC001) begin n_fail++; $display("FAIL b2b_max: got %h expected 3ffc001", product); end
    // start still high: the next edge re-accepts with operands 2 and 3
    @(posedge clk); #1;
    n_chk++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_reaccept: got %b expected 0", ready); end
    multiplicand = 13'd5; factor = 13'd5;
    repeat (5) @(posedge clk); #1;
    n_chk++;
    if (product !== 26'h3FFC001) begin n_fail++; $display("FAIL b2b_hold: got %h expected 3ffc001", product); end
    cyc = 5;
    while (!ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    start = 1'b0;
    n_chk++;
    if (cyc !== 14) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 14", cyc); end
    n_chk++;
    if (product !== 26'd6) begin n_fail++; $display("FAIL b2b_2x3: got %h expected 6", product); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    @(negedge clk);
    sign = 1'b0; multiplicand = 13'd100; factor = 13'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", ready); end
    n_chk++;
    if (product !== '0) begin n_fail++; $display("FAIL rst_mid_product: got %h expected 0", product); end
    @(negedge clk); reset_n = 1'b1;
    do_mul(1'b0, 13'd10, 13'd10, cyc);
    n_chk++;
    if (cyc !== 14) begin n_fail++; $display("FAIL rst_mid_latency: got %0d expected 14", cyc); end
    n_chk++;
    if (product !== 26'd100) begin n_fail++; $display("FAIL rst_mid_10x10: got %h expected 64", product); end
  endtask

  task automatic test_zero();
    int cyc;
    do_mul(1'b0, 13'd0, 13'h1FFF, cyc);
    n_chk++;
    if (cyc !== 14) begin n_fail++; $display("FAIL zero_latency: got %0d expected 14", cyc); end
    n_chk++;
    if (product !== '0) begin n_fail++; $display("FAIL zero_uns: got %h expected 0", product); end
    do_mul(1'b1, 13'd9, 13'd9, cyc);      // nonzero in between
    do_mul(1'b1, 13'h1FFF, 13'd0, cyc);
    n_chk++;
    if (product !== '0) begin n_fail++; $display("FAIL zero_sgn: got %h expected 0", product); end
  endtask

`ifdef MULTIPLIER_OVF_EN
  task automatic test_ovf();
    int cyc;
    do_mul(1'b0, 13'd128, 13'd64, cyc);
    n_chk++;
    if (product !== 26'd8192 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_128x64: got %h/%b expected 2000/1", product, ovf);
    end
    do_mul(1'b0, 13'd127, 13'd64, cyc);
    n_chk++;
    if (product !== 26'd8128 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_127x64: got %h/%b expected 1fc0/0", product, ovf);
    end
    do_mul(1'b1, 13'h1FC0, 13'd64, cyc);
    n_chk++;
    if (product !== 26'h3FFF000 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_m64x64: got %h/%b expected 3fff000/0", product, ovf);
    end
    do_mul(1'b1, 13'd64, 13'd64, cyc);
    n_chk++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_p64x64: got %b expected 1", ovf); end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_reset_midrun();
    test_zero();
`ifdef MULTIPLIER_OVF_EN
    test_ovf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_multiplier
